// File: rtl/muladd_pkg.sv
// muladd_pkg: shared MULADD widths, scheduler state encoding and default latency
package muladd_pkg;
    localparam int MULADD_A_W = 8;
    localparam int MULADD_C_W = 20;
    localparam int MAC_LAT_DEF = 1;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT = 2'd2;
    localparam state_t DONE = 2'd3;
endpackage

// File: rtl/muladd_lat_timer.sv
// muladd_lat_timer: 3-bit latency down-counter, expire flags the final cycle of a load
module muladd_lat_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       expire
);
    logic [2:0] cnt;
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 3'd1;
    assign expire = cnt == 3'd1;
endmodule

// File: rtl/muladd_dot_seq.sv
// muladd_dot_seq: sequences one MULADD tile as a dot-product engine with C-path accumulator feedback
module muladd_dot_seq
    import muladd_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [LEN_W-1:0]      job_len,
    input  logic [MULADD_C_W-1:0] job_bias,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [MULADD_A_W-1:0] op_a,
    input  logic [MULADD_A_W-1:0] op_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [MULADD_C_W-1:0] res_data,
    output logic [MULADD_A_W-1:0] mac_a,
    output logic [MULADD_A_W-1:0] mac_b,
    output logic [MULADD_C_W-1:0] mac_c,
    output logic                  mac_clr,
    input  logic [MULADD_C_W-1:0] mac_q,
    output logic                  busy
);
    state_t state, state_nxt;
    logic [MULADD_C_W-1:0] acc;
    logic [LEN_W-1:0] remaining;
    logic job_fire, op_fire, res_fire, lat_exp, mac_done;

    // readies are gated by reset too so nothing handshakes in a reset cycle
    assign job_ready = rst_n && !abort && state == IDLE;
    assign op_ready  = rst_n && !abort && state == ISSUE;
    assign job_fire  = job_valid && job_ready;
    assign op_fire   = op_valid && op_ready;
    assign res_valid = state == DONE;
    assign res_fire  = res_valid && res_ready;
    assign res_data  = acc;
    assign mac_done  = state == WAIT && lat_exp;
    assign mac_a     = op_fire ? op_a : '0;
    assign mac_b     = op_fire ? op_b : '0;
    assign mac_c     = op_fire ? acc : '0;
    assign mac_clr   = !rst_n || abort || job_fire;
    assign busy      = state != IDLE;

    muladd_lat_timer u_timer (
        .clk(CLK),
        .rst_n(rst_n),
        .load(op_fire),
        .load_val(3'(MAC_LAT)),
        .dec(state == WAIT),
        .expire(lat_exp)
    );

    always_comb
        state_nxt = abort ? IDLE :
                    job_fire ? (job_len == '0 ? DONE : ISSUE) :
                    op_fire ? WAIT :
                    mac_done ? (remaining == LEN_W'(1) ? DONE : ISSUE) :
                    res_fire ? IDLE : state;

    always_ff @(posedge CLK)
        if (!rst_n) begin
            state <= IDLE;
            acc <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (!abort && job_fire) begin
                acc <= job_bias;
                remaining <= job_len;
            end else if (!abort && mac_done) begin
                acc <= mac_q;
                remaining <= remaining - 1'b1;
            end
        end
endmodule

// File: tb/tb_muladd_dot_seq.sv
// tb_muladd_dot_seq: directed tests at MAC_LAT=1 and 3 against a transaction-level dot-product model
module tb_muladd_dot_seq;
    logic clk = 0;
    always #5 clk = ~clk;

    int sel = 0;
    logic rst_n = 0, abort = 0, job_valid = 0, op_valid = 0, res_ready = 0;
    logic [3:0] job_len = 0;
    logic [19:0] job_bias = 0;
    logic [7:0] op_a = 0, op_b = 0;
    logic job_ready, op_ready, res_valid, mac_clr, busy;
    logic [7:0] mac_a, mac_b;
    logic [19:0] mac_c, res_data, cap;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit started = 0;

    // two DUTs differing only in MAC_LAT; the unselected one is held in reset
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 1 : 3;
        logic jr, opr, rv, clr, bz;
        logic [7:0] ma, mb;
        logic [19:0] mc, rd;
        logic [19:0] pipe [8];
        muladd_dot_seq #(.LEN_W(4), .MAC_LAT(L)) dut (
            .CLK(clk), .rst_n(rst_n && sel == g), .abort(abort),
            .job_valid(job_valid), .job_ready(jr), .job_len(job_len), .job_bias(job_bias),
            .op_valid(op_valid), .op_ready(opr), .op_a(op_a), .op_b(op_b),
            .res_valid(rv), .res_ready(res_ready), .res_data(rd),
            .mac_a(ma), .mac_b(mb), .mac_c(mc), .mac_clr(clr), .mac_q(pipe[L-1]), .busy(bz)
        );
        always @(posedge clk) begin
            pipe[0] <= 20'(ma * mb + mc);
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign job_ready = sel == 1 ? u[1].jr  : u[0].jr;
    assign op_ready  = sel == 1 ? u[1].opr : u[0].opr;
    assign res_valid = sel == 1 ? u[1].rv  : u[0].rv;
    assign mac_clr   = sel == 1 ? u[1].clr : u[0].clr;
    assign busy      = sel == 1 ? u[1].bz  : u[0].bz;
    assign mac_a     = sel == 1 ? u[1].ma  : u[0].ma;
    assign mac_b     = sel == 1 ? u[1].mb  : u[0].mb;
    assign mac_c     = sel == 1 ? u[1].mc  : u[0].mc;
    assign res_data  = sel == 1 ? u[1].rd  : u[0].rd;

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (lat sel %0d, cycle %0d): got %h expected %h", nm, sel, cyc, act, exp);
        end
    endtask

    // model: one job at a time, expected result and handshake timing from the job rules
    bit m_job, m_pend, jf, of, rf;
    int m_rem, m_next, m_due, ml;
    logic [19:0] m_acc, m_exp;

    always @(negedge clk) begin
        cyc++;
        if (started) begin
            jf = job_valid && job_ready;
            of = op_valid && op_ready;
            rf = res_valid && res_ready;
            ml = sel == 1 ? 3 : 1;
            chk("job_ready", job_ready, rst_n && !abort && !m_job && !m_pend);
            chk("op_ready", op_ready, rst_n && !abort && m_job && cyc >= m_next);
            chk("busy", busy, m_job || m_pend);
            chk("res_valid", res_valid, m_pend && cyc >= m_due);
            if (res_valid) chk("res_data", res_data, m_exp);
            chk("mac_a", mac_a, of ? op_a : 8'd0);
            chk("mac_b", mac_b, of ? op_b : 8'd0);
            chk("mac_c", mac_c, of ? m_acc : 20'd0);
            chk("mac_clr", mac_clr, !rst_n || abort || jf);
            if (!rst_n || abort) begin
                m_job = 0;
                m_pend = 0;
            end else begin
                if (jf) begin
                    m_acc = job_bias;
                    m_rem = int'(job_len);
                    m_job = job_len != 0;
                    m_next = cyc + 1;
                    if (job_len == 0) begin
                        m_pend = 1;
                        m_exp = job_bias;
                        m_due = cyc + 1;
                    end
                end
                if (of) begin
                    m_acc = m_acc + op_a * op_b;
                    m_rem--;
                    m_next = cyc + ml + 1;
                    if (m_rem == 0) begin
                        m_job = 0;
                        m_pend = 1;
                        m_exp = m_acc;
                        m_due = cyc + ml + 1;
                    end
                end
                if (rf) m_pend = 0;
            end
        end
    end

    task automatic wait_rdy(input int kind, input string nm);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if ((kind == 0 && job_ready) || (kind == 1 && op_ready) || (kind == 2 && res_valid)) begin
                cap = res_data;
                @(posedge clk); #1;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s: no handshake within 100 cycles", nm);
    endtask

    task automatic send_job(input logic [3:0] len, input logic [19:0] bias);
        job_len = len;
        job_bias = bias;
        job_valid = 1;
        wait_rdy(0, "job");
        job_valid = 0;
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b);
        op_a = a;
        op_b = b;
        op_valid = 1;
        wait_rdy(1, "op");
        op_valid = 0;
        op_a = 0;
        op_b = 0;
    endtask

    task automatic get_res(input logic [19:0] exp, input string nm);
        res_ready = 1;
        wait_rdy(2, nm);
        res_ready = 0;
        chk(nm, cap, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n = 0;
            sel = s;
            tick();
            started = 1;
            tick();
            rst_n = 1;
            send_job(3, 20'd5);
            send_op(2, 3);
            send_op(4, 5);
            send_op(255, 255);
            get_res(20'd65056, "t1_dot");
            send_job(0, 20'hABCDE);
            get_res(20'hABCDE, "t2_len0");
            send_job(1, 20'hFFFFF);
            send_op(1, 1);
            get_res(20'h00000, "t3_wrap");
            send_job(4, 20'd0);
            send_op(1, 1);
            send_op(2, 2);
            abort = 1;
            @(negedge clk);
            chk("t4_abort_clr", mac_clr, 1);
            tick();
            abort = 0;
            @(negedge clk);
            chk("t4_abort_idle", busy, 0);
            tick();
            send_job(1, 20'd0);
            send_op(3, 3);
            get_res(20'd9, "t4_after_abort");
            send_job(1, 20'd7);
            send_op(2, 2);
            wait_rdy(2, "t5_done");
            job_len = 1;
            job_bias = 20'd100;
            job_valid = 1;
            repeat (10) begin
                @(negedge clk);
                chk("t5_hold_jr", job_ready, 0);
                chk("t5_hold_data", res_data, 20'd11);
                tick();
            end
            res_ready = 1;
            @(negedge clk);
            chk("t5_res_valid", res_valid, 1);
            tick();
            res_ready = 0;
            @(negedge clk);
            chk("t5_pending_job", job_ready, 1);
            tick();
            job_valid = 0;
            send_op(1, 1);
            get_res(20'd101, "t5_next_job");
            send_job(2, 20'd0);
            op_a = 5;
            op_b = 5;
            op_valid = 1;
            rst_n = 0;
            @(negedge clk);
            chk("t6_no_op", op_ready, 0);
            tick();
            rst_n = 1;
            op_valid = 0;
            @(negedge clk);
            chk("t6_idle", busy, 0);
            chk("t6_no_res", res_valid, 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
